// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle shared by the video pipeline blocks.
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 8
);
    localparam int KW = (TDATA_WIDTH + 7) / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tuser;
    logic                   tlast;
    logic [KW-1:0]          tkeep;
    logic [KW-1:0]          tstrb;
    logic [3:0]             tid;
    logic [3:0]             tdest;

    modport master (
        output tvalid, tdata, tuser, tlast, tkeep, tstrb, tid, tdest,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tuser, tlast, tkeep, tstrb, tid, tdest,
        output tready
    );
endinterface

// File: rtl/grad_combiner.sv
// grad_combiner: joins two gradient pixel streams beat-for-beat, checks
// tuser/tlast alignment and emits the saturated sum through two register
// stages. Optional macro GRAD_COMBINER_THRESHOLD_EN binarizes the output
// against threshold_i.
module grad_combiner #(
    parameter int PX_WIDTH    = 8,
    parameter int TDATA_WIDTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  video_a_i,
    axi4_stream_if.slave  video_b_i,
    axi4_stream_if.master video_o,
    input  logic          clear_i,
`ifdef GRAD_COMBINER_THRESHOLD_EN
    input  logic [PX_WIDTH-1:0] threshold_i,
`endif
    output logic          desync_o
);

    typedef enum logic {SYNC_WAIT, RUN} state_t;

    state_t state, state_n;

    logic                accept, mismatch, load_s1;
    logic                s1_valid, s1_ready, s1_user, s1_last;
    logic [PX_WIDTH:0]   s1_sum;
    logic                s2_valid, s2_ready, s2_user, s2_last;
    logic [PX_WIDTH-1:0] s2_px, sat_px, s2_px_n;

    // Sideband fields the block does not use.
    logic unused_inputs;
    assign unused_inputs = ^{video_a_i.tid, video_a_i.tdest, video_a_i.tkeep,
                             video_a_i.tstrb, video_a_i.tdata,
                             video_b_i.tid, video_b_i.tdest, video_b_i.tkeep,
                             video_b_i.tstrb, video_b_i.tdata};

    assign s2_ready = !s2_valid || video_o.tready;
    assign s1_ready = !s1_valid || s2_ready;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= SYNC_WAIT;
        else       state <= state_n;
    end

    // Next state and input handshakes: drop to SOF independently while
    // resyncing, then consume pairs jointly and check their framing.
    always_comb begin
        state_n           = state;
        accept            = 1'b0;
        mismatch          = 1'b0;
        video_a_i.tready  = 1'b0;
        video_b_i.tready  = 1'b0;
        case (state)
            SYNC_WAIT: begin
                video_a_i.tready = video_a_i.tvalid && !video_a_i.tuser;
                video_b_i.tready = video_b_i.tvalid && !video_b_i.tuser;
                if (video_a_i.tvalid && video_a_i.tuser &&
                    video_b_i.tvalid && video_b_i.tuser)
                    state_n = RUN;
            end
            RUN: begin
                accept           = video_a_i.tvalid && video_b_i.tvalid && s1_ready;
                video_a_i.tready = accept;
                video_b_i.tready = accept;
                mismatch         = accept &&
                                   ((video_a_i.tuser != video_b_i.tuser) ||
                                    (video_a_i.tlast != video_b_i.tlast));
                if (mismatch) state_n = SYNC_WAIT;
            end
            default: state_n = SYNC_WAIT;
        endcase
    end

    assign load_s1 = accept && !mismatch;

    // Stage 1: widened sum plus framing taken from stream a.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_user  <= 1'b0;
            s1_last  <= 1'b0;
        end else if (s1_ready) begin
            s1_valid <= load_s1;
            if (load_s1) begin
                s1_sum  <= {1'b0, video_a_i.tdata[PX_WIDTH-1:0]} +
                           {1'b0, video_b_i.tdata[PX_WIDTH-1:0]};
                s1_user <= video_a_i.tuser;
                s1_last <= video_a_i.tlast;
            end
        end
    end

    assign sat_px = s1_sum[PX_WIDTH] ? '1 : s1_sum[PX_WIDTH-1:0];
`ifdef GRAD_COMBINER_THRESHOLD_EN
    assign s2_px_n = (sat_px >= threshold_i) ? '1 : '0;
`else
    assign s2_px_n = sat_px;
`endif

    // Stage 2: saturated (or binarized) pixel; holds while the sink stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid <= 1'b0;
            s2_px    <= '0;
            s2_user  <= 1'b0;
            s2_last  <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_px   <= s2_px_n;
                s2_user <= s1_user;
                s2_last <= s1_last;
            end
        end
    end

    // Sticky misalignment flag; a new mismatch wins over clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         desync_o <= 1'b0;
        else if (mismatch) desync_o <= 1'b1;
        else if (clear_i)  desync_o <= 1'b0;
    end

    assign video_o.tvalid = s2_valid;
    assign video_o.tdata  = TDATA_WIDTH'(s2_px);
    assign video_o.tuser  = s2_user;
    assign video_o.tlast  = s2_last;
    assign video_o.tkeep  = '1;
    assign video_o.tstrb  = '1;
    assign video_o.tid    = '0;
    assign video_o.tdest  = '0;

endmodule

// File: tb/tb_grad_combiner.sv
// Directed bench for grad_combiner: table-driven frame plus sequences for
// resync, desync/clear, random stalls and mid-frame reset.
module tb_grad_combiner;

    typedef struct packed {
        logic       user;
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_sum;
        logic [7:0] exp_bin;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic clear_i = 1'b0;
    logic desync_o;
`ifdef GRAD_COMBINER_THRESHOLD_EN
    logic [7:0] threshold_i = 8'd128;
`endif

    axi4_stream_if #(.TDATA_WIDTH(8)) va ();
    axi4_stream_if #(.TDATA_WIDTH(8)) vb ();
    axi4_stream_if #(.TDATA_WIDTH(8)) vo ();

    grad_combiner #(.PX_WIDTH(8), .TDATA_WIDTH(8)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .video_a_i (va),
        .video_b_i (vb),
        .video_o   (vo),
        .clear_i   (clear_i),
`ifdef GRAD_COMBINER_THRESHOLD_EN
        .threshold_i (threshold_i),
`endif
        .desync_o  (desync_o)
    );

    always #5 clk_i = ~clk_i;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    beat_t qa[$], qb[$], got_q[$], exp_q[$];
    bit    gap_en = 1'b0, rdy_rand = 1'b0, lat_arm = 1'b0;
    bit    fire_a, fire_b, hold_chk = 1'b0;
    logic [9:0] held;
    int    first_acc = -1, first_out = -1;
    vec_t  tbl [8];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input logic u, input logic l, input logic [7:0] d);
        beat_t r;
        r.user = u; r.last = l; r.data = d;
        return r;
    endfunction

    // Saturating adder reference, optionally binarized at 128.
    function automatic logic [7:0] model_px(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] p;
        s = {1'b0, a} + {1'b0, b};
        p = s[8] ? 8'hff : s[7:0];
`ifdef GRAD_COMBINER_THRESHOLD_EN
        p = (p >= 8'd128) ? 8'hff : 8'h00;
`endif
        return p;
    endfunction

    task automatic push_beat(input logic [7:0] a, input logic [7:0] b, input logic u,
                             input logic la, input logic lb, input bit keep,
                             input logic [7:0] expd);
        qa.push_back(mk(u, la, a));
        qb.push_back(mk(u, lb, b));
        if (keep) exp_q.push_back(mk(u, la, expd));
    endtask

    // 4x2 frame of constant pixels; early_b moves b's first tlast to beat 2.
    task automatic push_frame(input logic [7:0] a, input logic [7:0] b,
                              input bit early_b, input int keep_n);
        for (int i = 0; i < 8; i++) begin
            logic l, lb;
            l  = (i == 3) || (i == 7);
            lb = early_b ? ((i == 2) || (i == 7)) : l;
            push_beat(a, b, i == 0, l, lb, i < keep_n, model_px(a, b));
        end
    endtask

    task automatic wait_out(input string nm, input int budget);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        repeat (8) @(posedge clk_i);
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_beat%0d", nm, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Driver/monitor: handshakes sampled on the falling edge, new inputs
    // presented just after the rising edge.
    initial begin
        va.tvalid = 0; va.tdata = 0; va.tuser = 0; va.tlast = 0;
        va.tkeep = 0; va.tstrb = 0; va.tid = 0; va.tdest = 0;
        vb.tvalid = 0; vb.tdata = 0; vb.tuser = 0; vb.tlast = 0;
        vb.tkeep = 0; vb.tstrb = 0; vb.tid = 0; vb.tdest = 0;
        vo.tready = 1;
        forever begin
            @(negedge clk_i);
            fire_a = va.tvalid && va.tready;
            fire_b = vb.tvalid && vb.tready;
            if (lat_arm && first_acc >= 0 && first_out < 0 && vo.tvalid && vo.tready)
                first_out = cyc;
            if (lat_arm && first_acc < 0 && fire_a && fire_b)
                first_acc = cyc;
            if (hold_chk && vo.tvalid && !rst_i)
                chk("stall_stable", {vo.tdata, vo.tuser, vo.tlast}, held);
            hold_chk = vo.tvalid && !vo.tready && !rst_i;
            held = {vo.tdata, vo.tuser, vo.tlast};
            if (vo.tvalid && vo.tready)
                got_q.push_back(mk(vo.tuser, vo.tlast, vo.tdata));
            @(posedge clk_i);
            #1;
            if (fire_a) void'(qa.pop_front());
            if (fire_b) void'(qb.pop_front());
            if (!va.tvalid || fire_a) begin
                if (qa.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                    va.tvalid = 1; {va.tuser, va.tlast, va.tdata} = qa[0];
                end else va.tvalid = 0;
            end
            if (!vb.tvalid || fire_b) begin
                if (qb.size() > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                    vb.tvalid = 1; {vb.tuser, vb.tlast, vb.tdata} = qb[0];
                end else vb.tvalid = 0;
            end
            vo.tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        tbl[0] = '{8'd100, 8'd50,  8'd150, 8'd255};
        tbl[1] = '{8'd100, 8'd50,  8'd150, 8'd255};
        tbl[2] = '{8'd200, 8'd100, 8'd255, 8'd255};
        tbl[3] = '{8'd0,   8'd255, 8'd255, 8'd255};
        tbl[4] = '{8'd127, 8'd128, 8'd255, 8'd255};
        tbl[5] = '{8'd100, 8'd27,  8'd127, 8'd0};
        tbl[6] = '{8'd100, 8'd50,  8'd150, 8'd255};
        tbl[7] = '{8'd255, 8'd255, 8'd255, 8'd255};

        // Reset state.
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_tvalid", vo.tvalid, 0);
        chk("rst_tdata", vo.tdata, 0);
        chk("rst_tuser_tlast", {vo.tuser, vo.tlast}, 0);
        chk("rst_desync", desync_o, 0);
        chk("rst_tkeep_tstrb", {vo.tkeep, vo.tstrb}, 2'b11);
        chk("rst_tid_tdest", {vo.tid, vo.tdest}, 0);
        rst_i = 0;

        // Junk ahead of SOF on a only: dropped, b held at SOF.
        @(posedge clk_i); #2;
        for (int i = 0; i < 3; i++) qa.push_back(mk(1'b0, 1'b0, 8'd9));
        push_frame(8'd100, 8'd50, 1'b0, 8);
        wait_out("junk", 200);
        chk("junk_desync", desync_o, 0);

        // Table frame: sums and saturation, framing on beats 0/3/7, latency.
        first_acc = -1; first_out = -1; lat_arm = 1;
        for (int i = 0; i < 8; i++)
`ifdef GRAD_COMBINER_THRESHOLD_EN
            push_beat(tbl[i].a, tbl[i].b, i == 0, (i == 3) || (i == 7),
                      (i == 3) || (i == 7), 1'b1, tbl[i].exp_bin);
`else
            push_beat(tbl[i].a, tbl[i].b, i == 0, (i == 3) || (i == 7),
                      (i == 3) || (i == 7), 1'b1, tbl[i].exp_sum);
`endif
        wait_out("table", 200);
        lat_arm = 0;
        chk("latency", first_out - first_acc, 2);
        chk("table_desync", desync_o, 0);

        // Early tlast on b: two beats survive, third pair dropped, resync.
        push_frame(8'd100, 8'd50, 1'b1, 2);
        push_frame(8'd10, 8'd20, 1'b0, 8);
        wait_out("desync", 300);
        chk("desync_set", desync_o, 1);
        @(posedge clk_i); #2 clear_i = 1;
        @(posedge clk_i); #2 clear_i = 0;
        chk("desync_clear", desync_o, 0);

        // Random gaps and backpressure over three frames.
        gap_en = 1; rdy_rand = 1;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 8; i++) begin
                logic [7:0] a, b;
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                push_beat(a, b, i == 0, (i == 3) || (i == 7), (i == 3) || (i == 7),
                          1'b1, model_px(a, b));
            end
        wait_out("random", 3000);
        chk("random_desync", desync_o, 0);
        gap_en = 0; rdy_rand = 0;

`ifdef GRAD_COMBINER_THRESHOLD_EN
        // Binarization at 128: 127 -> 0, 128 -> 255, 300 -> 255.
        push_beat(8'd100, 8'd27,  1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        push_beat(8'd100, 8'd28,  1'b0, 1'b0, 1'b0, 1'b1, 8'd255);
        push_beat(8'd200, 8'd100, 1'b0, 1'b1, 1'b1, 1'b1, 8'd255);
        wait_out("thresh", 200);
`endif

        // Reset mid-frame: output drops at once, next common SOF restarts.
        @(posedge clk_i); #2;
        push_frame(8'd30, 8'd40, 1'b0, 0);
        push_frame(8'd60, 8'd70, 1'b0, 8);
        repeat (5) @(posedge clk_i);
        #2;
        chk("pre_rst_tvalid", vo.tvalid, 1);
        rst_i = 1;
        got_q.delete();
        #1 chk("rst_mid_tvalid", vo.tvalid, 0);
        repeat (2) @(posedge clk_i);
        #2 rst_i = 0;
        wait_out("rst_mid", 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grad_combiner.md
Name: grad_combiner

Overview:
- Downstream of two parallel conv_2d instances, e.g. horizontal and vertical Sobel kernels fed from the same source.
- Joins the two AXI4-Stream pixel streams beat-for-beat, checks frame/line alignment via tuser/tlast, and outputs the saturated sum of the pixel pair.
- A resync state machine realigns the inputs on frame start after reset or after a detected misalignment.
- Feeds the next image-processing stage or video output.

Parameters:
- PX_WIDTH, 8, pixel bit width; inputs use tdata[PX_WIDTH-1:0].
- TDATA_WIDTH, 8, tdata width of all three streams; must be >= PX_WIDTH.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- video_a_i  axi4_stream_if.slave  TDATA_WIDTH  first gradient stream; tuser = start of frame, tlast = end of line.
- video_b_i  axi4_stream_if.slave  TDATA_WIDTH  second gradient stream; same framing.
- video_o  axi4_stream_if.master  TDATA_WIDTH  combined pixel stream.
- clear_i  input  1  single-cycle pulse; clears desync_o.
- desync_o  output  1  sticky flag; set when a tuser/tlast mismatch is detected.
- threshold_i  input  PX_WIDTH  binarization threshold; present only with GRAD_COMBINER_THRESHOLD_EN.

Behaviour:
- Reset values:
  - state = SYNC_WAIT; all pipeline valids 0; desync_o = 0.
  - video_o.tvalid = 0; tdata/tuser/tlast = 0.
  - video_o.tkeep and video_o.tstrb = '1 at all times.
- State SYNC_WAIT:
  - Per input, tready = tvalid && !tuser, so non-SOF beats are dropped independently on each stream.
  - A stream whose head beat has tuser = 1 is held with tready = 0.
  - When both heads carry tuser = 1, move to RUN in the next cycle. No beat is consumed on the transition cycle.
- State RUN, joint handshake:
  - accept = a.tvalid && b.tvalid && s1_ready.
  - a.tready = b.tready = accept. Both beats are always consumed together; one stream never advances alone.
- Alignment check on each accepted pair:
  - If a.tuser != b.tuser or a.tlast != b.tlast: the pair is dropped (not written to the pipeline), desync_o is set, and the state returns to SYNC_WAIT in the next cycle.
- Pipeline, two register stages with per-stage valid:
  - s1 = a_px + b_px, PX_WIDTH+1 bits, tuser and tlast from a.
  - s2 = s1[PX_WIDTH] ? 2^PX_WIDTH-1 : s1[PX_WIDTH-1:0], zero-extended to TDATA_WIDTH.
  - video_o is driven directly from s2 registers.
  - Latency: accepted pair at edge N appears on video_o at edge N+2 with no stall.
  - s2_ready = !s2_valid || video_o.tready; s1_ready = !s1_valid || s2_ready.
  - Full throughput: 1 pixel/clk.
  - Under backpressure, video_o data is held stable while tvalid && !tready. No loss or duplication.
- desync_o:
  - Set has priority over clear_i in the same cycle.
  - clear_i with no mismatch clears desync_o on the next edge.
- Reset mid-operation:
  - Pipeline contents are discarded; the state returns to SYNC_WAIT.
  - Partially received frames are dropped until the next tuser on both inputs.
- Input tid, tdest, tkeep and tstrb are ignored. Output tid and tdest = 0.

Optional Feature:
- Macro GRAD_COMBINER_THRESHOLD_EN.
- Defined:
  - threshold_i port exists.
  - Stage 2 outputs 2^PX_WIDTH-1 when the saturated sum >= threshold_i, else 0.
  - threshold_i is sampled at the stage-2 register load. Latency unchanged.
- Undefined: no threshold_i port; output is the saturated sum.

Test Plan:
1. Aligned 4x2 frames, a = 100, b = 50 on every beat, video_o.tready = 1 -> video_o.tdata = 150, first beat 2 cycles after the first joint accept, tuser on beat 0, tlast on beats 3 and 7, desync_o = 0.
2. a = 200, b = 100 -> 255 (saturated); a = 0, b = 255 -> 255; a = 127, b = 128 -> 255; a = 100, b = 27 -> 127.
3. Stream a carries 3 non-SOF junk beats before the frame start; b starts cleanly -> junk dropped, b held at SOF, output frame fully aligned, desync_o stays 0.
4. Stream b asserts tlast one beat early in line 0 -> desync_o = 1 at the mismatching pair, that pair is absent from the output, output resumes at the next frame start. A clear_i pulse then sets desync_o = 0.
5. Random video_o.tready (50%) and random input tvalid gaps over 3 frames -> output sequence equals the reference model exactly, and tdata is stable during stalls.
6. With GRAD_COMBINER_THRESHOLD_EN, threshold_i = 128: sums 127 -> 0, 128 -> 255, 300 -> 255. Separately, assert rst_i mid-frame -> video_o.tvalid = 0 immediately, and output restarts at the next common tuser.
